// File: rtl/uart_pkg.sv
// Shared UART receive-path constants and types.
package uart_pkg;
  localparam int UART_BYTE_W = 8;
  localparam int RX_DEPTH = 16;
  localparam int RX_AW = 4;
  localparam int RX_IRQ_THRESH = 1;
  localparam int RX_TIMEOUT_CYC = 1024;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Receive FIFO storage: DEPTH x byte registers,
// one write port, asynchronous read.
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_DEPTH,
  parameter int AW = RX_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  uart_byte_t    wdata,
  input  logic [AW-1:0] raddr,
  output uart_byte_t    rdata
);
  uart_byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_buf_ctrl.sv
// UART receive buffer controller: edge-detected push, show-ahead FIFO,
// overflow and irq. Optional idle timeout: UART_RX_BUF_CTRL_TIMEOUT_EN.
module uart_rx_buf_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_DEPTH,
  parameter int AW = RX_AW,
  parameter int IRQ_THRESH = RX_IRQ_THRESH,
  parameter int TIMEOUT_CYC = RX_TIMEOUT_CYC
) (
  input  logic          clk,
  input  logic          RSTn,
  input  uart_byte_t    rx_data,
  input  logic          rx_done,
  input  logic          rd_en,
  output uart_byte_t    rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  input  logic          flush,
  input  logic          ovf_clr,
  output logic          overflow,
`ifdef UART_RX_BUF_CTRL_TIMEOUT_EN
  output logic          tmo_flag,
`endif
  output logic          irq
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] THR_C = (AW+1)'(IRQ_THRESH);

  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt, cnt_next;
  logic          rx_done_d;
  logic          ovf_q, ovf_next;
  logic          irq_q, irq_next;
  logic          push_edge, do_push, do_pop, ovf_evt;
  uart_byte_t    head;

  uart_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wptr),
    .wdata (rx_data),
    .raddr (rptr),
    .rdata (head)
  );

  always_comb begin
    push_edge = rx_done & ~rx_done_d;
    do_pop    = rd_en & (cnt != '0) & ~flush;
    do_push   = push_edge & ~flush & ((cnt != DEPTH_C) | do_pop);
    ovf_evt   = push_edge & ~flush & (cnt == DEPTH_C) & ~do_pop;
    cnt_next  = cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    if (flush) cnt_next = '0;
    ovf_next = ovf_q;
    if (flush)        ovf_next = 1'b0;
    else if (ovf_evt) ovf_next = 1'b1;
    else if (ovf_clr) ovf_next = 1'b0;
  end

`ifdef UART_RX_BUF_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);

  logic [TW-1:0] idle, idle_next;
  logic          tmo_q, tmo_next;

  // Idle counting only while data sits below the threshold irq.
  always_comb begin
    idle_next = idle;
    if (flush | do_push | do_pop)
      idle_next = '0;
    else if (cnt != '0 && cnt < THR_C && idle != TMAX)
      idle_next = idle + 1'b1;
    tmo_next = tmo_q;
    if (flush | do_pop)        tmo_next = 1'b0;
    else if (idle_next == TMAX) tmo_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      idle  <= '0;
      tmo_q <= 1'b0;
    end else begin
      idle  <= idle_next;
      tmo_q <= tmo_next;
    end
  end

  assign tmo_flag = tmo_q;
  assign irq_next = (cnt_next >= THR_C) | ovf_next | tmo_next;
`else
  assign irq_next = (cnt_next >= THR_C) | ovf_next;
`endif

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      rx_done_d <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      rx_done_d <= rx_done;
      ovf_q     <= ovf_next;
      irq_q     <= irq_next;
      cnt       <= cnt_next;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (do_push) wptr <= wptr + 1'b1;
        if (do_pop)  rptr <= rptr + 1'b1;
      end
    end
  end

  assign rd_valid = (cnt != '0);
  assign rd_data  = rd_valid ? head : 8'h00;
  assign count    = cnt;
  assign overflow = ovf_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_uart_rx_buf_ctrl.sv
// Directed vector bench for uart_rx_buf_ctrl.
// Timeout sequence runs only with UART_RX_BUF_CTRL_TIMEOUT_EN.
module tb_uart_rx_buf_ctrl;
  import uart_pkg::*;

  typedef struct {
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rd_en;
    logic       flush;
    logic       ovf_clr;
    logic [4:0] e_count;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_ovf;
    logic       e_irq;
  } vec_t;

  logic       clk = 1'b0;
  logic       RSTn;
  logic [7:0] rx_data;
  logic       rx_done, rd_en, flush, ovf_clr;
  logic [7:0] rd_data;
  logic       rd_valid, overflow, irq;
  logic [4:0] count;

  int nvec = 0;
  int nbad = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  uart_rx_buf_ctrl #(
    .DEPTH(16), .AW(4), .IRQ_THRESH(1), .TIMEOUT_CYC(1024)
  ) dut (
    .clk(clk), .RSTn(RSTn), .rx_data(rx_data), .rx_done(rx_done),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .flush(flush), .ovf_clr(ovf_clr),
    .overflow(overflow),
`ifdef UART_RX_BUF_CTRL_TIMEOUT_EN
    .tmo_flag(),
`endif
    .irq(irq)
  );

`ifdef UART_RX_BUF_CTRL_TIMEOUT_EN
  logic       t_valid, t_ovf, t_irq, t_tmo;
  logic [7:0] t_data;
  logic [4:0] t_count;

  uart_rx_buf_ctrl #(
    .DEPTH(16), .AW(4), .IRQ_THRESH(4), .TIMEOUT_CYC(8)
  ) dut_tmo (
    .clk(clk), .RSTn(RSTn), .rx_data(rx_data), .rx_done(rx_done),
    .rd_en(rd_en), .rd_data(t_data), .rd_valid(t_valid),
    .count(t_count), .flush(flush), .ovf_clr(ovf_clr),
    .overflow(t_ovf), .tmo_flag(t_tmo), .irq(t_irq)
  );
`endif

  function automatic vec_t mk(logic d, logic [7:0] x, logic r,
                              logic f, logic oc, int c,
                              logic [7:0] h, logic o, logic q);
    vec_t v;
    v.rx_done = d;  v.rx_data = x;  v.rd_en = r;
    v.flush = f;    v.ovf_clr = oc;
    v.e_count = 5'(c);
    v.e_valid = (c != 0);
    v.e_data = h;   v.e_ovf = o;    v.e_irq = q;
    return v;
  endfunction

  task automatic drive(vec_t v);
    rx_done = v.rx_done; rx_data = v.rx_data;
    rd_en = v.rd_en; flush = v.flush; ovf_clr = v.ovf_clr;
  endtask

  task automatic check(string name, vec_t v);
    logic [15:0] act, exp;
    act = {count, rd_valid, rd_data, overflow, irq};
    exp = {v.e_count, v.e_valid, v.e_data, v.e_ovf, v.e_irq};
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got cnt=%0d vld=%b data=%h ovf=%b irq=%b, want cnt=%0d vld=%b data=%h ovf=%b irq=%b",
               name, count, rd_valid, rd_data, overflow, irq,
               v.e_count, v.e_valid, v.e_data, v.e_ovf, v.e_irq);
    end
  endtask

  task automatic step(string name, vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check(name, v);
  endtask

  initial begin
    // idle
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
    // one push from a 3-cycle rx_done, then pop
    vq.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 8'hA5, 0, 1));
    vq.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 8'hA5, 0, 1));
    vq.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 8'hA5, 0, 1));
    vq.push_back(mk(0, 8'hA5, 0, 0, 0, 1, 8'hA5, 0, 1));
    vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));
    // 17 bytes; the last overflows with ovf_clr coincident (set wins)
    for (int i = 0; i < 17; i++) begin
      vq.push_back(mk(1, 8'(i), 0, 0, i == 16,
                      (i < 16) ? i + 1 : 16, 8'h00, i == 16, 1));
      vq.push_back(mk(0, 8'(i), 0, 0, 0,
                      (i < 16) ? i + 1 : 16, 8'h00, i == 16, 1));
    end
    for (int j = 0; j < 16; j++)
      vq.push_back(mk(0, 8'h00, 1, 0, 0, 15 - j,
                      (j < 15) ? 8'(j + 1) : 8'h00, 1, 1));
    vq.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0));
    // refill, then push+pop while full
    for (int i = 0; i < 16; i++) begin
      vq.push_back(mk(1, 8'(32 + i), 0, 0, 0, i + 1, 8'h20, 0, 1));
      vq.push_back(mk(0, 8'(32 + i), 0, 0, 0, i + 1, 8'h20, 0, 1));
    end
    vq.push_back(mk(1, 8'h55, 1, 0, 0, 16, 8'h21, 0, 1));
    vq.push_back(mk(0, 8'h55, 0, 0, 0, 16, 8'h21, 0, 1));
    for (int j = 0; j < 16; j++)
      vq.push_back(mk(0, 8'h00, 1, 0, 0, 15 - j,
                      (j < 14) ? 8'(34 + j) :
                      (j == 14) ? 8'h55 : 8'h00, 0, j < 15));
    // rd_en while empty
    vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));
    // flush coincident with a push edge; held rx_done not re-pushed
    vq.push_back(mk(1, 8'hB1, 0, 0, 0, 1, 8'hB1, 0, 1));
    vq.push_back(mk(0, 8'hB1, 0, 0, 0, 1, 8'hB1, 0, 1));
    vq.push_back(mk(1, 8'hC3, 0, 1, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(1, 8'hC3, 0, 0, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 8'hC3, 0, 0, 0, 0, 8'h00, 0, 0));

    RSTn = 1'b0;
    drive(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("reset", mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
    RSTn = 1'b1;

    foreach (vq[k])
      step($sformatf("vec%0d", k), vq[k]);

    // reset while rx_done already high: byte pushed exactly once after
    RSTn = 1'b0;
    step("rst_mid", mk(1, 8'h7E, 0, 0, 0, 0, 8'h00, 0, 0));
    RSTn = 1'b1;
    step("rst_exit", mk(1, 8'h7E, 0, 0, 0, 1, 8'h7E, 0, 1));
    step("rst_hold", mk(1, 8'h7E, 0, 0, 0, 1, 8'h7E, 0, 1));
    step("rst_low", mk(0, 8'h7E, 0, 0, 0, 1, 8'h7E, 0, 1));
    step("rst_flush", mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0));

`ifdef UART_RX_BUF_CTRL_TIMEOUT_EN
    step("tmo_push", mk(1, 8'h3C, 0, 0, 0, 1, 8'h3C, 0, 1));
    nvec++;
    if (t_tmo !== 1'b0 || t_irq !== 1'b0 || t_count !== 5'd1) begin
      nbad++;
      $display("FAIL tmo_start: got tmo=%b irq=%b cnt=%0d, want 0 0 1",
               t_tmo, t_irq, t_count);
    end
    drive(mk(0, 8'h3C, 0, 0, 0, 0, 8'h00, 0, 0));
    repeat (7) @(posedge clk);
    #1;
    nvec++;
    if (t_tmo !== 1'b0 || t_irq !== 1'b0) begin
      nbad++;
      $display("FAIL tmo_early: got tmo=%b irq=%b, want 0 0",
               t_tmo, t_irq);
    end
    @(posedge clk);
    #1;
    nvec++;
    if (t_tmo !== 1'b1 || t_irq !== 1'b1) begin
      nbad++;
      $display("FAIL tmo_fire: got tmo=%b irq=%b, want 1 1",
               t_tmo, t_irq);
    end
    step("tmo_pop", mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));
    nvec++;
    if (t_tmo !== 1'b0 || t_irq !== 1'b0 || t_valid !== 1'b0) begin
      nbad++;
      $display("FAIL tmo_clear: got tmo=%b irq=%b vld=%b, want 0 0 0",
               t_tmo, t_irq, t_valid);
    end
    drive(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
